// File: rtl/ct_spsram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM (ct_spsram_param).
// Parity support is compiled in with CT_SPSRAM_PARITY_EN.
package ct_spsram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int RD_LAT_ONE = 1;
    localparam int RD_LAT_TWO = 2;

    // Widest segment the parity helper can fold; narrower segments are zero-extended.
    localparam int PAR_MAX_W = 1024;

    function automatic int seg_width(input int data_w, input int we_w);
        return data_w / we_w;
    endfunction

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ct_spsram_param_if.sv
// Request/response bundle of ct_spsram_param; PINJ/PERR exist only with CT_SPSRAM_PARITY_EN.
interface ct_spsram_param_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int WE_WIDTH   = 128
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [WE_WIDTH-1:0]   WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  QVLD;
    logic                  BUSY;
`ifdef CT_SPSRAM_PARITY_EN
    logic                  PINJ;
    logic                  PERR;

    modport master (output A, CEN, GWEN, WEN, D, PINJ, input Q, QVLD, BUSY, PERR);
    modport slave  (input A, CEN, GWEN, WEN, D, PINJ, output Q, QVLD, BUSY, PERR);
`else
    modport master (output A, CEN, GWEN, WEN, D, input Q, QVLD, BUSY);
    modport slave  (input A, CEN, GWEN, WEN, D, output Q, QVLD, BUSY);
`endif
endinterface

// File: rtl/ct_spsram_init_seq.sv
// Post-reset zero-fill sequencer: sweeps every word once, then reports ready.
module ct_spsram_init_seq
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int INIT_CLR   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    // One extra counter bit keeps the terminal compare clear of wrap-around.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    // Next-state and sweep counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    state_d = CLEAR;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_CLR != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = (state_q == CLEAR) && !rst;
    assign clr_addr = cnt_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ct_spsram_param.sv
// Parametrised single-port SRAM with masked writes, 1/2-cycle read path and post-reset clear.
// Optional per-segment parity (PINJ/PERR) is enabled by defining CT_SPSRAM_PARITY_EN.
module ct_spsram_param
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int WE_WIDTH   = 128,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLR   = 1
) (
    input  logic CLK,
    input  logic RST,
    ct_spsram_param_if.slave bus
);
    localparam int SEG   = seg_width(DATA_WIDTH, WE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % WE_WIDTH) != 0) begin : g_bad_we_width
            $error("ct_spsram_param: WE_WIDTH must divide DATA_WIDTH");
        end
        if ((RD_LAT != RD_LAT_ONE) && (RD_LAT != RD_LAT_TWO)) begin : g_bad_rd_lat
            $error("ct_spsram_param: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic                  busy_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;

    ct_spsram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_CLR   (INIT_CLR)
    ) u_init_seq (
        .clk      (CLK),
        .rst      (RST),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  acc_s;
    logic                  rd_acc_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [WE_WIDTH-1:0]   wr_smask_s;
    logic [DATA_WIDTH-1:0] wr_bmask_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Access decode; the clear sweep owns the array port while busy.
    always_comb begin
        acc_s      = !bus.CEN && !busy_s && !RST;
        rd_acc_s   = acc_s && bus.GWEN;
        wr_en_s    = 1'b0;
        wr_addr_s  = bus.A;
        wr_data_s  = bus.D;
        wr_smask_s = '0;
        wr_bmask_s = '0;
        if (clr_we_s) begin
            wr_en_s    = 1'b1;
            wr_addr_s  = clr_addr_s;
            wr_data_s  = '0;
            wr_smask_s = '1;
        end else if (acc_s && !bus.GWEN) begin
            wr_en_s    = 1'b1;
            wr_smask_s = ~bus.WEN;
        end else begin
            wr_en_s    = 1'b0;
        end
        for (int i = 0; i < WE_WIDTH; i++) begin
            wr_bmask_s[i*SEG +: SEG] = {SEG{wr_smask_s[i]}};
        end
        rd_data_s = mem_q[bus.A];
    end

`ifdef CT_SPSRAM_PARITY_EN
    logic [WE_WIDTH-1:0]  par_mem_q [DEPTH];
    logic [WE_WIDTH-1:0]  wr_par_s;
    logic [WE_WIDTH-1:0]  rd_calc_s;
    logic [PAR_MAX_W-1:0] wr_seg_s;
    logic [PAR_MAX_W-1:0] rd_seg_s;
    logic                 rd_perr_s;

    // Per-segment parity for writes (PINJ flips it) and for checking the word being read.
    always_comb begin
        wr_par_s  = '0;
        rd_calc_s = '0;
        wr_seg_s  = '0;
        rd_seg_s  = '0;
        for (int i = 0; i < WE_WIDTH; i++) begin
            wr_seg_s            = '0;
            wr_seg_s[SEG-1:0]   = wr_data_s[i*SEG +: SEG];
            wr_par_s[i]         = even_parity(wr_seg_s) ^ (bus.PINJ & ~clr_we_s);
            rd_seg_s            = '0;
            rd_seg_s[SEG-1:0]   = rd_data_s[i*SEG +: SEG];
            rd_calc_s[i]        = even_parity(rd_seg_s);
        end
        rd_perr_s = |(rd_calc_s ^ par_mem_q[bus.A]);
    end
`endif

    // Behavioural array write; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= (mem_q[wr_addr_s] & ~wr_bmask_s) | (wr_data_s & wr_bmask_s);
`ifdef CT_SPSRAM_PARITY_EN
            par_mem_q[wr_addr_s] <= (par_mem_q[wr_addr_s] & ~wr_smask_s) | (wr_par_s & wr_smask_s);
`endif
        end
    end

    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  qvld_q, qvld_d;

    // Read pipeline; Q holds whenever no result arrives.
    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = 1'b0;
        q_d       = q_q;
        qvld_d    = 1'b0;
        if (RD_LAT == RD_LAT_TWO) begin
            s1_vld_d  = rd_acc_s;
            s1_data_d = rd_acc_s ? rd_data_s : s1_data_q;
            if (s1_vld_q) begin
                q_d    = s1_data_q;
                qvld_d = 1'b1;
            end else begin
                q_d    = q_q;
            end
        end else begin
            if (rd_acc_s) begin
                q_d    = rd_data_s;
                qvld_d = 1'b1;
            end else begin
                q_d    = q_q;
            end
        end
    end

    // Read pipeline registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
            q_q       <= '0;
            qvld_q    <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
            q_q       <= q_d;
            qvld_q    <= qvld_d;
        end
    end

`ifdef CT_SPSRAM_PARITY_EN
    logic s1_perr_q, s1_perr_d;
    logic perr_q, perr_d;

    // Parity error travels alongside the read data and is only raised with QVLD.
    always_comb begin
        s1_perr_d = 1'b0;
        perr_d    = 1'b0;
        if (RD_LAT == RD_LAT_TWO) begin
            s1_perr_d = rd_acc_s & rd_perr_s;
            perr_d    = s1_vld_q & s1_perr_q;
        end else begin
            perr_d    = rd_acc_s & rd_perr_s;
        end
    end

    // Parity error registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_perr_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            s1_perr_q <= s1_perr_d;
            perr_q    <= perr_d;
        end
    end

    assign bus.PERR = perr_q;
`endif

    assign bus.Q    = q_q;
    assign bus.QVLD = qvld_q;
    assign bus.BUSY = busy_s;

endmodule

// File: tb/tb_ct_spsram_param.sv
// Bench for ct_spsram_param: RD_LAT=2 and RD_LAT=1 instances share one stimulus stream.
// Parity checks are included when CT_SPSRAM_PARITY_EN is defined.
module tb_ct_spsram_param;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int WW    = 4;
    localparam int SEGW  = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] a;
    logic          cen;
    logic          gwen;
    logic [WW-1:0] wen;
    logic [DW-1:0] d;
    logic          pinj;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ct_spsram_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bus2 ();
    ct_spsram_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bus1 ();

    assign bus2.A = a;  assign bus2.CEN = cen; assign bus2.GWEN = gwen; assign bus2.WEN = wen; assign bus2.D = d;
    assign bus1.A = a;  assign bus1.CEN = cen; assign bus1.GWEN = gwen; assign bus1.WEN = wen; assign bus1.D = d;
`ifdef CT_SPSRAM_PARITY_EN
    assign bus2.PINJ = pinj;
    assign bus1.PINJ = pinj;
`endif

    ct_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .RD_LAT(2), .INIT_CLR(1))
        dut_l2 (.CLK(clk), .RST(rst), .bus(bus2));
    ct_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .RD_LAT(1), .INIT_CLR(1))
        dut_l1 (.CLK(clk), .RST(rst), .bus(bus1));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          perr;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    logic [WW-1:0] m_bad [DEPTH];
    rd_t           pend1[$];
    rd_t           pend2[$];
    int            m_rem  = 0;
    int            n_edge = 0;
    logic [DW-1:0] e_q1 = '0, e_q2 = '0;
    logic          e_v1 = 1'b0, e_v2 = 1'b0, e_p1 = 1'b0, e_p2 = 1'b0;
    logic          e_busy = 1'b1;

    initial begin
        rd_t r;
        forever begin
            @(posedge clk);
            n_edge++;
            if (rst) begin
                m_rem = DEPTH;
                pend1.delete();
                pend2.delete();
                e_q1 = '0;
                e_q2 = '0;
            end else if (m_rem > 0) begin
                m_mem[DEPTH - m_rem] = '0;
                m_bad[DEPTH - m_rem] = '0;
                m_rem--;
            end else if (!cen) begin
                if (!gwen) begin
                    for (int i = 0; i < WW; i++) begin
                        if (!wen[i]) begin
                            m_mem[a][i*SEGW +: SEGW] = d[i*SEGW +: SEGW];
                            m_bad[a][i] = pinj;
                        end
                    end
                end else begin
                    r.data = m_mem[a];
                    r.perr = |m_bad[a];
                    r.due  = n_edge;
                    pend1.push_back(r);
                    r.due  = n_edge + 1;
                    pend2.push_back(r);
                end
            end
            e_v1 = 1'b0; e_p1 = 1'b0;
            e_v2 = 1'b0; e_p2 = 1'b0;
            if (pend1.size() > 0 && pend1[0].due == n_edge) begin
                r = pend1.pop_front();
                e_q1 = r.data; e_v1 = 1'b1; e_p1 = r.perr;
            end
            if (pend2.size() > 0 && pend2[0].due == n_edge) begin
                r = pend2.pop_front();
                e_q2 = r.data; e_v2 = 1'b1; e_p2 = r.perr;
            end
            e_busy = (m_rem > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("l2_busy", 64'(bus2.BUSY), 64'(e_busy));
                check("l1_busy", 64'(bus1.BUSY), 64'(e_busy));
                check("l2_qvld", 64'(bus2.QVLD), 64'(e_v2));
                check("l1_qvld", 64'(bus1.QVLD), 64'(e_v1));
                check("l2_q",    64'(bus2.Q),    64'(e_q2));
                check("l1_q",    64'(bus1.Q),    64'(e_q1));
`ifdef CT_SPSRAM_PARITY_EN
                check("l2_perr", 64'(bus2.PERR), 64'(e_p2));
                check("l1_perr", 64'(bus1.PERR), 64'(e_p1));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic op(input logic c, input logic g, input logic [WW-1:0] w,
                      input logic [AW-1:0] ad, input logic [DW-1:0] dd, input logic pj);
        @(negedge clk);
        cen = c; gwen = g; wen = w; a = ad; d = dd; pinj = pj;
    endtask

    task automatic idle();
        op(1'b1, 1'b1, 4'hF, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dd, input logic [WW-1:0] w);
        op(1'b0, 1'b0, w, ad, dd, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] ad);
        op(1'b0, 1'b1, 4'hF, ad, 32'h0, 1'b0);
    endtask

    // Single read followed by idles; pins both latencies against a literal.
    task automatic rd_chk(input string nm, input logic [AW-1:0] ad, input logic [DW-1:0] exp);
        rd(ad);
        idle();
        check({nm, "_l1_vld"}, 64'(bus1.QVLD), 64'd1);
        check({nm, "_l1_q"},   64'(bus1.Q),    64'(exp));
        check({nm, "_l2_early"}, 64'(bus2.QVLD), 64'd0);
        idle();
        check({nm, "_l2_vld"}, 64'(bus2.QVLD), 64'd1);
        check({nm, "_l2_q"},   64'(bus2.Q),    64'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        rst = 1'b1; cen = 1'b1; gwen = 1'b1; wen = 4'hF; a = 4'h0; d = 32'h0; pinj = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_l2_q",    64'(bus2.Q),    64'd0);
        check("rst_l2_qvld", 64'(bus2.QVLD), 64'd0);
        check("rst_l1_busy", 64'(bus1.BUSY), 64'd1);
        chk_en = 1'b1;

        // Clear sweep length after reset release
        rst = 1'b0;
        cnt = 0;
        while (bus2.BUSY && cnt < 40) begin cnt++; idle(); end
        check("busy_cycles", 64'(cnt), 64'd16);

        for (int i = 0; i < DEPTH; i++) begin
            rd(4'(i));
            if (i > 0) begin
                check("clr_rd_vld", 64'(bus1.QVLD), 64'd1);
                check("clr_rd_q",   64'(bus1.Q),    64'd0);
            end
        end
        repeat (2) idle();

        // Latency and back-to-back ordering
        wr(4'd5, 32'h0000A5A5, 4'h0);
        rd_chk("rd5", 4'd5, 32'h0000A5A5);
        wr(4'd6, 32'h00005A5A, 4'h0);
        rd(4'd5);
        rd(4'd6);
        idle();
        check("b2b_first_vld", 64'(bus2.QVLD), 64'd1);
        check("b2b_first_q",   64'(bus2.Q),    64'h0000A5A5);
        idle();
        check("b2b_second_vld", 64'(bus2.QVLD), 64'd1);
        check("b2b_second_q",   64'(bus2.Q),    64'h00005A5A);

        // CEN=1 write attempt is ignored and Q holds
        rd_chk("pre_cen", 4'd5, 32'h0000A5A5);
        op(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0);
        idle();
        idle();
        check("cen_hold_q",   64'(bus2.Q),    64'h0000A5A5);
        check("cen_hold_vld", 64'(bus2.QVLD), 64'd0);
        rd_chk("cen_keep", 4'd5, 32'h0000A5A5);

        // Segment masking and no-op write
        wr(4'd7, 32'hFFFFFFFF, 4'h0);
        wr(4'd7, 32'h00000000, 4'b1010);
        rd_chk("mask", 4'd7, 32'hFF00FF00);
        wr(4'd7, 32'h00000000, 4'hF);
        rd_chk("noop", 4'd7, 32'hFF00FF00);

        // Mixed directed pattern, checked by the model
        for (int i = 0; i < 12; i++) begin
            wr(4'(i), 32'h13579BDF ^ (32'(i) * 32'h01010101), 4'(i * 5));
            if (i % 3 == 2) rd(4'(i - 1));
        end
        for (int i = 0; i < DEPTH; i++) rd(4'(DEPTH - 1 - i));
        repeat (2) idle();

        // Reset kills an in-flight read
        rd(4'd5);
        @(negedge clk);
        rst = 1'b1; cen = 1'b1;
        @(negedge clk);
        check("kill_l2_vld", 64'(bus2.QVLD), 64'd0);
        check("kill_l2_q",   64'(bus2.Q),    64'd0);
        check("kill_l1_q",   64'(bus1.Q),    64'd0);

        // Reset at sweep count 9 restarts the clear; busy requests are dropped
        rst = 1'b0;
        repeat (9) idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (bus2.BUSY && cnt < 40) begin
            cnt++;
            if (cnt == 10) wr(4'd3, 32'h00001234, 4'h0);
            else idle();
        end
        check("busy_restart", 64'(cnt), 64'd16);
        rd_chk("busy_drop", 4'd3, 32'h0);
        rd_chk("restart_clr5", 4'd5, 32'h0);

`ifdef CT_SPSRAM_PARITY_EN
        op(1'b0, 1'b0, 4'h0, 4'd2, 32'h0F0F0F01, 1'b1);
        rd(4'd2);
        idle();
        check("pinj_l1_perr", 64'(bus1.PERR), 64'd1);
        idle();
        check("pinj_l2_perr", 64'(bus2.PERR), 64'd1);
        wr(4'd2, 32'h0F0F0F01, 4'h0);
        rd(4'd2);
        idle();
        check("clean_l1_perr", 64'(bus1.PERR), 64'd0);
        check("clean_l1_vld",  64'(bus1.QVLD), 64'd1);
        idle();
        check("clean_l2_perr", 64'(bus2.PERR), 64'd0);
`endif

        repeat (3) idle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
